// File: rtl/sqrt_pkg.sv
// Shared constants for the Newton square-root
// sequencer and its state-to-control decoder.
package sqrt_pkg;

    typedef enum logic [3:0] {
        S0  = 4'd0,
        S1  = 4'd1,
        S2  = 4'd2,
        S3  = 4'd3,
        S4  = 4'd4,
        S5  = 4'd5,
        S6  = 4'd6,
        S7  = 4'd7,
        S8  = 4'd8,
        S9  = 4'd9,
        S10 = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_DIV = 2'b10,
        ALU_ABS = 2'b11
    } alu_op_t;

    localparam logic [2:0] REG_N      = 3'd1;
    localparam logic [2:0] REG_X      = 3'd2;
    localparam logic [2:0] REG_ROOT   = 3'd3;
    localparam logic [2:0] REG_TEMP   = 3'd4;
    localparam logic [2:0] REG_CONST2 = 3'd5;
    localparam logic [2:0] REG_I      = 3'd6;

    function automatic logic is_legal(input logic [3:0] s);
        return s <= 4'd10;
    endfunction

endpackage

// File: rtl/sqrt_state_seq_if.sv
// Handshake bundle between the sequencer and its
// requester / control decoder.
// master: drives start, alu_neg; sees state + status.
// slave : the sequencer itself.
interface sqrt_state_seq_if #(
    parameter int ITER_W = 5
);

    logic              start;
    logic              alu_neg;
    logic [3:0]        current_state;
    logic              busy;
    logic              done;
    logic [ITER_W-1:0] iter_count;
    logic              timeout;

    modport master (
        output start,
        output alu_neg,
        input  current_state,
        input  busy,
        input  done,
        input  iter_count,
        input  timeout
    );

    modport slave (
        input  start,
        input  alu_neg,
        output current_state,
        output busy,
        output done,
        output iter_count,
        output timeout
    );

endinterface

// File: rtl/sqrt_iter_ctr.sv
// Iteration counter: clear on run start, bump on each
// S8 exit. at_limit only exists with SQRT_ITER_LIMIT_EN.
// Ports: clk, rst, clear, incr -> count, at_limit.
module sqrt_iter_ctr #(
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              incr,
    output logic [ITER_W-1:0] count,
    output logic              at_limit
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + 1'b1;
        end
    end

`ifdef SQRT_ITER_LIMIT_EN
    // True while evaluating the last permitted S8.
    assign at_limit = (count == ITER_W'(MAX_ITER - 1));
`else
    assign at_limit = 1'b0;
`endif

endmodule

// File: rtl/sqrt_state_seq.sv
// Newton square-root sequencer FSM with start/busy/done
// handshake and iteration count.
// Ports: clk, rst (async, active high), bus (slave):
//   start, alu_neg in; current_state, busy, done,
//   iter_count, timeout out.
// Option: SQRT_ITER_LIMIT_EN forces exit after MAX_ITER
//   S8 checks and flags timeout.
module sqrt_state_seq
    import sqrt_pkg::*;
#(
    parameter int MAX_ITER = 16,
    parameter int ITER_W   = 5
) (
    input  logic            clk,
    input  logic            rst,
    sqrt_state_seq_if.slave bus
);

    if (MAX_ITER < 1 || MAX_ITER >= (1 << ITER_W)) begin : g_cfg_bad
        $error("ITER_W too narrow for MAX_ITER");
    end

    state_t state_q;
    state_t state_d;

    logic accept;
    logic leave_s8;
    logic at_limit;

    assign accept   = (state_q == S0) && bus.start;
    assign leave_s8 = (state_q == S8);

    sqrt_iter_ctr #(
        .MAX_ITER (MAX_ITER),
        .ITER_W   (ITER_W)
    ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .clear    (accept),
        .incr     (leave_s8),
        .count    (bus.iter_count),
        .at_limit (at_limit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S0;
        unique case (state_q)
            S0:  state_d = bus.start ? S1 : S0;
            S1:  state_d = S2;
            S2:  state_d = S3;
            S3:  state_d = S4;
            S4:  state_d = S5;
            S5:  state_d = S6;
            S6:  state_d = S7;
            S7:  state_d = S8;
            // Converged, or out of iterations.
            S8:  state_d = (bus.alu_neg || at_limit) ? S10 : S9;
            S9:  state_d = S3;
            S10: state_d = S0;
            default: state_d = S0;
        endcase
    end

`ifdef SQRT_ITER_LIMIT_EN
    logic timeout_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (accept) begin
            timeout_q <= 1'b0;
        end else if (leave_s8 && !bus.alu_neg && at_limit) begin
            timeout_q <= 1'b1;
        end
    end
`endif

    // Moore outputs from the registered state only.
    always_comb begin
        bus.current_state = state_q;
        bus.busy          = is_legal(state_q) && (state_q != S0);
        bus.done          = (state_q == S10);
`ifdef SQRT_ITER_LIMIT_EN
        bus.timeout       = timeout_q;
`else
        bus.timeout       = 1'b0;
`endif
    end

endmodule

// File: tb/tb_sqrt_state_seq.sv
// Self-checking bench for sqrt_state_seq: trace-based
// model of each run, random start/alu_neg noise.
module tb_sqrt_state_seq;
    import sqrt_pkg::*;

    localparam int MAXI = 4;
    localparam int IW   = 5;
`ifdef SQRT_ITER_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sqrt_state_seq_if #(.ITER_W(IW)) bus ();

    sqrt_state_seq #(
        .MAX_ITER (MAXI),
        .ITER_W   (IW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int exp_iter = 0;
    bit exp_to = 1'b0;

    task automatic chk(input string name, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d",
                     name, act, exp);
        end
    endtask

    task automatic chk_all(input int st);
        chk("state", int'(bus.current_state), st);
        chk("busy", int'(bus.busy), (st != 0) ? 1 : 0);
        chk("done", int'(bus.done), (st == 10) ? 1 : 0);
        chk("iter", int'(bus.iter_count), exp_iter);
        chk("timeout", int'(bus.timeout), int'(exp_to));
    endtask

    // Expected state after each clock of a run with n
    // convergence checks requested (first alu_neg=1 at
    // the n-th S8), ending back in S0.
    task automatic build(input int n, output int q[$],
                         output bit to);
        int it;
        it = n;
        to = 1'b0;
        if (LIM && n > MAXI) begin
            it = MAXI;
            to = 1'b1;
        end
        q = {};
        for (int s = 1; s <= 8; s++) q.push_back(s);
        for (int i = 2; i <= it; i++) begin
            q.push_back(9);
            for (int s = 3; s <= 8; s++) q.push_back(s);
        end
        q.push_back(10);
        q.push_back(0);
    endtask

    task automatic run(input int n, input int abort_idx,
                       input bit hold);
        int q[$];
        bit to;
        int pre;
        int eights;
        build(n, q, to);
        pre = 0;
        eights = 0;
        for (int j = 0; j < q.size(); j++) begin
            bus.start = (j == 0 || hold) ? 1'b1
                      : 1'($urandom_range(0, 1));
            if (pre == 8)
                bus.alu_neg = (eights + 1 == n);
            else
                bus.alu_neg = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (j == 0) begin
                exp_iter = 0;
                exp_to = 1'b0;
            end
            if (pre == 8) begin
                eights++;
                exp_iter = (exp_iter + 1) % (1 << IW);
                if (q[j] == 10 && to) exp_to = 1'b1;
            end
            chk_all(q[j]);
            if (j == abort_idx) begin
                #2 rst = 1'b1;
                #1;
                exp_iter = 0;
                exp_to = 1'b0;
                chk_all(0);
                #1 rst = 1'b0;
                return;
            end
            pre = q[j];
        end
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            bus.start = 1'b0;
            bus.alu_neg = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            chk_all(0);
        end
    endtask

    initial begin
        int q[$];
        bit to;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.alu_neg = 1'b0;
        #1;
        chk_all(0);
        #11 rst = 1'b0;

        // Model pins: fastest run S1..S10 = 9 states,
        // two passes take 16 cycles S1..S10.
        build(1, q, to);
        chk("pin_len1", q.size(), 10);
        chk("pin_s10_1", q[8], 10);
        build(2, q, to);
        chk("pin_len2", q.size(), 17);
        chk("pin_s10_2", q[15], 10);
        chk("pin_9_2", q[8], 9);

        idle(2);
        run(1, -1, 1'b0);
        chk("single_iter", int'(bus.iter_count), 1);
        chk("single_to", int'(bus.timeout), 0);
        idle(1);
        run(2, -1, 1'b0);
        chk("double_iter", int'(bus.iter_count), 2);
        idle(1);

        // Limit case: alu_neg never asserted before 6th S8.
        run(6, -1, 1'b0);
`ifdef SQRT_ITER_LIMIT_EN
        chk("limit_iter", int'(bus.iter_count), 4);
        chk("limit_to", int'(bus.timeout), 1);
`else
        chk("limit_iter", int'(bus.iter_count), 6);
        chk("limit_to", int'(bus.timeout), 0);
`endif
        idle(1);

        // Reset in S5 of the second pass.
        run(3, 11, 1'b0);
        idle(2);

        // start held high: back-to-back runs.
        run(1, -1, 1'b1);
        run(2, -1, 1'b1);
        idle(1);

        // Illegal code recovers to S0, busy low meanwhile.
        @(negedge clk);
        force dut.state_q = state_t'(4'd13);
        #1;
        chk("illegal_state", int'(bus.current_state), 13);
        chk("illegal_busy", int'(bus.busy), 0);
        chk("illegal_done", int'(bus.done), 0);
        release dut.state_q;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("illegal_recover", int'(bus.current_state), 0);
        idle(1);

        for (int r = 0; r < 30; r++) begin
            run($urandom_range(1, 6), -1,
                1'($urandom_range(0, 3) == 0));
            idle($urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks",
                 errors, checks);
        $finish;
    end

endmodule
